// File: rtl/apb_seg_display_if.sv
`timescale 1ns/1ps
// APB bus bundle for the seven-segment display controller.
// Handshake: a write is accepted on the setup phase (PSEL & ~PENABLE & PWRITE)
// and lands on the next PCLK edge; PREADY is always 1 so every transfer
// completes without wait states, and PRDATA is valid combinationally from PADDR.
interface apb_seg_display_if;
  logic        PSEL;
  logic [11:2] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_seg_display.sv
`timescale 1ns/1ps
// Six-digit multiplexed seven-segment display controller with an APB register
// file, frame-coherent shadow registers, leading-zero blanking, decimal points
// and 16-level brightness PWM. dbg_scan mirrors the scan FSM state.
module apb_seg_display (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  apb_seg_display_if.slave        apb,
  output logic [7:0]              seg,
  output logic [5:0]              dig,
  output logic                    dbg_scan
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [15:0] PRESC_RESET  = 16'd24999;
  localparam logic [3:0]  BRIGHT_RESET = 4'd15;

  // Software-visible registers
  logic [23:0] data_q,   data_d;
  logic [2:0]  ctrl_q,   ctrl_d;     // [0] EN, [1] HEX, [2] LZB
  logic [5:0]  dp_q,     dp_d;
  logic [15:0] presc_q,  presc_d;
  logic [3:0]  bright_q, bright_d;

  // Scan state
  state_t      state_q,  state_d;
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic [2:0]  idx_q,    idx_d;
  logic [3:0]  pwm_cnt_q, pwm_cnt_d;
  logic        frame_q,  frame_d;
  logic [23:0] sh_data_q, sh_data_d;
  logic [5:0]  sh_dp_q,  sh_dp_d;

  // Registered display outputs
  logic [7:0]  seg_q,    seg_d;
  logic [5:0]  dig_q,    dig_d;

  logic        wr_en;
  logic [2:0]  addr;
  logic        scanning;
  logic        unused_bits;

  assign wr_en       = apb.PSEL & ~apb.PENABLE & apb.PWRITE;
  assign addr        = apb.PADDR[4:2];
  assign unused_bits = ^{apb.PADDR[11:5], apb.PWDATA[31:24]};

  // Scanning continues only while both the current and next state are SCAN,
  // so the cycle that enters SCAN and the cycle that leaves it both hold reset.
  assign scanning    = (state_q == ST_SCAN) && (state_d == ST_SCAN);

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign seg         = seg_q;
  assign dig         = dig_q;
  assign dbg_scan    = (state_q == ST_SCAN);

  // 4-bit code to {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Register file write decode
  always_comb begin
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    dp_d     = dp_q;
    presc_d  = presc_q;
    bright_d = bright_q;
    if (wr_en) begin
      case (addr)
        3'd0:    data_d   = apb.PWDATA[23:0];
        3'd1:    ctrl_d   = apb.PWDATA[2:0];
        3'd2:    dp_d     = apb.PWDATA[5:0];
        3'd3:    presc_d  = apb.PWDATA[15:0];
        3'd4:    bright_d = apb.PWDATA[3:0];
        default: ;
      endcase
    end
  end

  // Read mux, combinational from the address
  always_comb begin
    apb.PRDATA = 32'h0;
    case (addr)
      3'd0:    apb.PRDATA = {8'h00, data_q};
      3'd1:    apb.PRDATA = {29'h0, ctrl_q};
      3'd2:    apb.PRDATA = {26'h0, dp_q};
      3'd3:    apb.PRDATA = {16'h0, presc_q};
      3'd4:    apb.PRDATA = {28'h0, bright_q};
      3'd5:    apb.PRDATA = {28'h0, frame_q, idx_q};
      default: apb.PRDATA = 32'h0;
    endcase
  end

  // FSM next state: SCAN follows EN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ctrl_q[0])  state_d = ST_SCAN;
      ST_SCAN: if (!ctrl_q[0]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler, digit index, PWM counter and shadow reloads
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    idx_d       = idx_q;
    pwm_cnt_d   = pwm_cnt_q;
    frame_d     = frame_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    if (scanning) begin
      pwm_cnt_d = pwm_cnt_q + 4'd1;
      // >= so that a PRESC lowered below the running count still advances
      if (presc_cnt_q >= presc_q) begin
        presc_cnt_d = 16'd0;
        if (idx_q == 3'd5) begin
          idx_d     = 3'd0;
          frame_d   = ~frame_q;
          sh_data_d = data_q;
          sh_dp_d   = dp_q;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        presc_cnt_d = presc_cnt_q + 16'd1;
      end
    end else begin
      presc_cnt_d = 16'd0;
      idx_d       = 3'd0;
      pwm_cnt_d   = 4'd0;
      // Entering SCAN captures the frame; a same-cycle write lands next frame
      if (state_q == ST_IDLE && state_d == ST_SCAN) begin
        sh_data_d = data_q;
        sh_dp_d   = dp_q;
      end
    end
  end

  // FSM outputs: digit decode, blanking and PWM gating ahead of the output flops
  always_comb begin
    logic [7:0] blank_vec;
    logic [7:0] dp_ext;
    logic [3:0] code;
    logic [6:0] glyph;
    blank_vec = 8'h00;
    dp_ext    = {2'b00, sh_dp_q};
    code      = 4'(sh_data_q >> {idx_q, 2'b00});
    glyph     = 7'h00;
    seg_d     = 8'h00;
    dig_d     = 6'h3F;
    // Blanking ripples down from digit 5 while digits stay zero; digit 0 never blanks
    if (ctrl_q[2]) begin
      blank_vec[5] = (sh_data_q[23:20] == 4'd0);
      for (int i = 4; i >= 1; i--) begin
        blank_vec[i] = blank_vec[i+1] && (sh_data_q[i*4 +: 4] == 4'd0);
      end
    end
    if (!blank_vec[idx_q] && (ctrl_q[1] || code <= 4'd9)) begin
      glyph = seg_decode(code);
    end
    if (scanning && (pwm_cnt_q <= bright_q)) begin
      seg_d = {dp_ext[idx_q], glyph};
      dig_d = ~(6'b000001 << idx_q);
    end
  end

  // State and register flops
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      data_q      <= 24'h0;
      ctrl_q      <= 3'h0;
      dp_q        <= 6'h0;
      presc_q     <= PRESC_RESET;
      bright_q    <= BRIGHT_RESET;
      state_q     <= ST_IDLE;
      presc_cnt_q <= 16'h0;
      idx_q       <= 3'd0;
      pwm_cnt_q   <= 4'd0;
      frame_q     <= 1'b0;
      sh_data_q   <= 24'h0;
      sh_dp_q     <= 6'h0;
      seg_q       <= 8'h00;
      dig_q       <= 6'h3F;
    end else begin
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      dp_q        <= dp_d;
      presc_q     <= presc_d;
      bright_q    <= bright_d;
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      idx_q       <= idx_d;
      pwm_cnt_q   <= pwm_cnt_d;
      frame_q     <= frame_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
    end
  end

endmodule

// File: tb/tb_apb_seg_display.sv
`timescale 1ns/1ps
// Bench for apb_seg_display: register readback, scan timing and content against
// a digit-level reference model, mid-frame shadowing, disable and async reset.
module tb_apb_seg_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg;
  logic [5:0] dig;
  logic       dbg_scan;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] exp_q[$];
  logic [31:0] m_regs [0:4];

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  apb_seg_display_if apb();

  apb_seg_display dut (
    .PCLK     (clk),
    .PRESETn  (rst_n),
    .apb      (apb),
    .seg      (seg),
    .dig      (dig),
    .dbg_scan (dbg_scan)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_regs[0] = 32'h0;
    m_regs[1] = 32'h0;
    m_regs[2] = 32'h0;
    m_regs[3] = 32'h0000_61A7;
    m_regs[4] = 32'h0000_000F;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b1;
    apb.PADDR   = {7'($urandom_range(0, 127)), a};
    apb.PWDATA  = d;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    @(negedge clk);
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    case (a)
      3'd0: m_regs[0] = {8'h0, d[23:0]};
      3'd1: m_regs[1] = {29'h0, d[2:0]};
      3'd2: m_regs[2] = {26'h0, d[5:0]};
      3'd3: m_regs[3] = {16'h0, d[15:0]};
      3'd4: m_regs[4] = {28'h0, d[3:0]};
      default: ;
    endcase
  endtask

  // Registers 5..7 read 0 whenever the scanner is idle with frame bit clear
  function automatic logic [31:0] model_read(input logic [2:0] a);
    if (a <= 3'd4) return m_regs[a];
    return 32'h0;
  endfunction

  task automatic read_check(input logic [2:0] a, input string tag);
    apb.PADDR = {7'($urandom_range(0, 127)), a};
    #1;
    check(tag, apb.PRDATA, model_read(a));
  endtask

  task automatic read_status(output logic [31:0] v);
    apb.PADDR = {7'($urandom_range(0, 127)), 3'd5};
    #1;
    v = apb.PRDATA;
  endtask

  // ---------------- reference model ----------------
  // Expected {seg, dig} for digit pos of a lit slot, from the display rules
  function automatic logic [13:0] exp_digit(input int pos, input logic [23:0] data,
                                            input logic [5:0] dp, input logic [2:0] ctrl);
    int          nib;
    bit          blank;
    logic [6:0]  glyph;
    logic [5:0]  digv;
    nib   = int'((data >> (4 * pos)) & 24'hF);
    blank = ctrl[2] && (pos > 0) && ((data >> (4 * pos)) == 24'h0);
    if (blank || (!ctrl[1] && nib > 9)) glyph = 7'h00;
    else                                glyph = SEG_TAB[nib];
    digv      = 6'h3F;
    digv[pos] = 1'b0;
    return {dp[pos], glyph, digv};
  endfunction

  // Build the expected stream for nframes frames; lit when (k mod 16) <= bright
  task automatic build_exp(input int nframes, input int presc, input int bright,
                           input logic [23:0] d_first, input logic [23:0] d_rest,
                           input logic [5:0] dp, input logic [2:0] ctrl);
    int f;
    f = 6 * (presc + 1);
    exp_q.delete();
    for (int k = 0; k < nframes * f; k++) begin
      if ((k % 16) > bright) exp_q.push_back({8'h00, 6'h3F});
      else exp_q.push_back(exp_digit((k / (presc + 1)) % 6, (k < f) ? d_first : d_rest, dp, ctrl));
    end
  endtask

  // Pop and compare one sample per cycle; status idx/frame checked when asked
  task automatic consume_exp(input int presc, input logic f0, input bit chk_status);
    int          k;
    int          f;
    logic [13:0] e;
    f = 6 * (presc + 1);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("scan_seg", {24'h0, seg}, {24'h0, e[13:6]});
      check("scan_dig", {26'h0, dig}, {26'h0, e[5:0]});
      if (chk_status) begin
        check("status_idx",   {29'h0, apb.PRDATA[2:0]}, 32'(((k + 1) / (presc + 1)) % 6));
        check("status_frame", {31'h0, apb.PRDATA[3]},   {31'h0, f0 ^ 1'(((k + 1) / f) & 1)});
      end
      k++;
    end
  endtask

  task automatic disable_check();
    logic [31:0] st;
    write_reg(3'd1, 32'h0);
    read_status(st);
    check("off_dig", {26'h0, dig}, 32'h3F);
    check("off_seg", {24'h0, seg}, 32'h0);
    check("off_idx", {29'h0, st[2:0]}, 32'h0);
    check("off_fsm", {31'h0, dbg_scan}, 32'h0);
  endtask

  task automatic run_config(input logic [23:0] data, input logic [5:0] dp, input logic [2:0] ctrl,
                            input int presc, input int bright);
    logic [31:0] st;
    logic        f0;
    write_reg(3'd0, {8'h0, data});
    write_reg(3'd2, {26'h0, dp});
    write_reg(3'd3, 32'(presc));
    write_reg(3'd4, 32'(bright));
    read_status(st);
    f0 = st[3];
    build_exp(2, presc, bright, data, data, dp, ctrl);
    write_reg(3'd1, {29'h0, ctrl | 3'b001});
    // One cycle after the EN edge the output is still dark
    read_status(st);
    check("start_dark_dig", {26'h0, dig}, 32'h3F);
    check("start_fsm", {31'h0, dbg_scan}, 32'h1);
    consume_exp(presc, f0, 1'b1);
    disable_check();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] st;
    logic [23:0] d_old;
    logic [23:0] d_new;
    logic [2:0]  a;
    logic [31:0] d;

    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_seg", {24'h0, seg}, 32'h0);
    check("rst_dig", {26'h0, dig}, 32'h3F);
    check("rst_pready", {31'h0, apb.PREADY}, 32'h1);
    check("rst_pslverr", {31'h0, apb.PSLVERR}, 32'h0);
    for (int i = 0; i < 8; i++) read_check(3'(i), "rst_reg");

    // Random register writes with readback; EN kept clear
    for (int i = 0; i < 24; i++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d[0] = 1'b0;
      write_reg(a, d);
      read_check(3'($urandom_range(0, 7)), "rand_reg");
      read_check(a, "rand_reg_same");
    end
    check("idle_dig", {26'h0, dig}, 32'h3F);

    // Directed scan configurations
    run_config(24'h123456, 6'h00, 3'b001, 3, 15);
    run_config(24'h0000A7, 6'h20, 3'b111, 3, 15);
    run_config(24'h0000A7, 6'h20, 3'b011, 3, 15);
    run_config(24'($urandom), 6'($urandom), 3'($urandom), 15, 3);
    run_config(24'h000000, 6'h3F, 3'b101, 0, 15);
    // Randomized scan configurations
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      if (d[0]) d[23:12] = 12'h0;
      run_config(d[23:0], 6'($urandom), 3'($urandom), $urandom_range(0, 5), $urandom_range(0, 15));
    end

    // Mid-frame DATA write: the current frame keeps the old value
    d_old = 24'($urandom);
    d_new = ~d_old;
    write_reg(3'd0, {8'h0, d_old});
    write_reg(3'd2, 32'h0);
    write_reg(3'd3, 32'd3);
    write_reg(3'd4, 32'd15);
    build_exp(2, 3, 15, d_old, d_new, 6'h00, 3'b011);
    write_reg(3'd1, 32'h3);
    check("mid_dark_dig", {26'h0, dig}, 32'h3F);
    fork
      consume_exp(3, 1'b0, 1'b0);
      begin
        repeat (8) @(negedge clk);
        write_reg(3'd0, {8'h0, d_new});
      end
    join

    // Asynchronous reset mid-scan
    repeat (5) @(negedge clk);
    check("pre_rst_lit", {31'h0, (dig != 6'h3F)}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_seg", {24'h0, seg}, 32'h0);
    check("arst_dig", {26'h0, dig}, 32'h3F);
    check("arst_fsm", {31'h0, dbg_scan}, 32'h0);
    read_check(3'd3, "arst_presc");
    read_check(3'd1, "arst_ctrl");
    read_check(3'd0, "arst_data");
    @(negedge clk);
    rst_n = 1'b1;
    read_status(st);
    check("arst_status", st, 32'h0);
    repeat (3) @(negedge clk);
    check("post_rst_dig", {26'h0, dig}, 32'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
